// File: rtl/video_sprite_array.sv
// Sprite engine: N indexed sprites with fixed priority, hflip, colour key, vblank-latched positions.
// Optional collision detector and status register when VIDEO_SPRITE_COLLISION_EN is defined.
module video_sprite_array #(
  parameter int unsigned SPRITES     = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned HEIGHT      = 32,
  parameter logic [7:0]  TRANSPARENT = 8'h00
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [15:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  input  logic        i_video_hblank,
  input  logic        i_video_vblank,
  input  logic [10:0] i_overlay_x,
  input  logic [10:0] i_overlay_y,
  output logic [7:0]  o_overlay_data,
  output logic        o_overlay_mask
);

  localparam int unsigned DEPTH = WIDTH * HEIGHT;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MEMD  = 1 << AW;
  localparam int unsigned XB    = $clog2(WIDTH);
  localparam logic [10:0] W11   = 11'(WIDTH);
  localparam logic [10:0] H11   = 11'(HEIGHT);

  logic [7:0]         mem_q   [SPRITES][MEMD];
  logic [10:0]        shx_q   [SPRITES];
  logic [10:0]        shx_d   [SPRITES];
  logic [10:0]        shy_q   [SPRITES];
  logic [10:0]        shy_d   [SPRITES];
  logic [10:0]        actx_q  [SPRITES];
  logic [10:0]        actx_d  [SPRITES];
  logic [10:0]        acty_q  [SPRITES];
  logic [10:0]        acty_d  [SPRITES];
  logic [SPRITES-1:0] en_q, en_d, flip_q, flip_d;
  logic               vbl_q;
  logic               ready_q, ready_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [SPRITES-1:0] hit_q, hit_d;
  logic [AW-1:0]      paddr_q [SPRITES];
  logic [AW-1:0]      paddr_d [SPRITES];
  logic               blank_q, blank_d;
  logic [7:0]         data_q, data_d;
  logic               mask_q, mask_d;

  logic [11:0]        dx [SPRITES];
  logic [11:0]        dy [SPRITES];
  logic [10:0]        col [SPRITES];
  logic [10:0]        lin [SPRITES];
  logic [7:0]         pix [SPRITES];
  logic [SPRITES-1:0] opaque;
  logic [31:0]        col_rdata;

  logic [3:0]    region;
  logic          is_status;
  logic          vbl_rise;
  logic [AW-1:0] wr_idx;
  logic          unused_wdata;

  assign region       = i_address[15:12];
  assign is_status    = (i_address[11:0] == 12'hFF0);
  assign vbl_rise     = i_video_vblank & ~vbl_q;
  assign wr_idx       = i_address[AW+1:2];
  assign unused_wdata = ^i_wdata[31:11];

  // Register file; a position write coinciding with the vblank copy lands in
  // the shadow only, because the copy reads the pre-write shadow value.
  always_comb begin
    shx_d   = shx_q;
    shy_d   = shy_q;
    actx_d  = actx_q;
    acty_d  = acty_q;
    en_d    = en_q;
    flip_d  = flip_q;
    ready_d = i_request;
    rdata_d = '0;
    if (vbl_rise) begin
      actx_d = shx_q;
      acty_d = shy_q;
    end
    if (i_request && region == 4'd0) begin
      if (is_status && !i_rw) rdata_d = col_rdata;
      for (int unsigned n = 0; n < SPRITES; n++) begin
        if (i_address[11:4] == 8'(n)) begin
          if (i_rw) begin
            case (i_address[3:0])
              4'h0: shx_d[n] = i_wdata[10:0];
              4'h4: shy_d[n] = i_wdata[10:0];
              4'h8: begin
                en_d[n]   = i_wdata[0];
                flip_d[n] = i_wdata[1];
              end
              default: ;
            endcase
          end else begin
            case (i_address[3:0])
              4'h0:    rdata_d = {21'd0, shx_q[n]};
              4'h4:    rdata_d = {21'd0, shy_q[n]};
              4'h8:    rdata_d = {30'd0, flip_q[n], en_q[n]};
              default: rdata_d = '0;
            endcase
          end
        end
      end
    end
  end

  // Stage 1: 12-bit difference so a borrow (pixel left of/above the sprite) is a miss
  always_comb begin
    hit_d   = '0;
    blank_d = i_video_hblank | i_video_vblank;
    for (int unsigned n = 0; n < SPRITES; n++) begin
      dx[n]      = {1'b0, i_overlay_x} - {1'b0, actx_q[n]};
      dy[n]      = {1'b0, i_overlay_y} - {1'b0, acty_q[n]};
      hit_d[n]   = en_q[n] && !dx[n][11] && !dy[n][11] &&
                   (dx[n][10:0] < W11) && (dy[n][10:0] < H11);
      col[n]     = flip_q[n] ? (W11 - 11'd1 - dx[n][10:0]) : dx[n][10:0];
      lin[n]     = (dy[n][10:0] << XB) | col[n];
      paddr_d[n] = lin[n][AW-1:0];
    end
  end

  // Stage 2: highest index applied first so the lowest opaque index wins
  always_comb begin
    data_d = '0;
    for (int unsigned n = 0; n < SPRITES; n++) begin
      pix[n]    = mem_q[n][paddr_q[n]];
      opaque[n] = hit_q[n] && (pix[n] != TRANSPARENT);
    end
    for (int unsigned n = 0; n < SPRITES; n++) begin
      if (opaque[SPRITES-1-n]) data_d = pix[SPRITES-1-n];
    end
    mask_d = (|opaque) && !blank_q;
  end

`ifdef VIDEO_SPRITE_COLLISION_EN
  logic [SPRITES-1:0] colst_q, colst_d;

  always_comb begin
    colst_d = colst_q;
    if (i_request && region == 4'd0 && is_status)
      colst_d = i_rw ? (colst_q & ~i_wdata[SPRITES-1:0]) : '0;
    if (!blank_q && ((opaque & (opaque - SPRITES'(1))) != '0))
      colst_d = colst_d | opaque;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) colst_q <= '0;
    else         colst_q <= colst_d;
  end

  assign col_rdata = 32'(colst_q);
`else
  assign col_rdata = '0;
`endif

  always_ff @(posedge i_clock) begin
    for (int unsigned n = 0; n < SPRITES; n++) begin
      if (i_request && i_rw && region == 4'(n + 1)) mem_q[n][wr_idx] <= i_wdata[7:0];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shx_q   <= '{default: '0};
      shy_q   <= '{default: '0};
      actx_q  <= '{default: '0};
      acty_q  <= '{default: '0};
      paddr_q <= '{default: '0};
      en_q    <= '0;
      flip_q  <= '0;
      vbl_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      hit_q   <= '0;
      blank_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= 1'b0;
    end else begin
      shx_q   <= shx_d;
      shy_q   <= shy_d;
      actx_q  <= actx_d;
      acty_q  <= acty_d;
      paddr_q <= paddr_d;
      en_q    <= en_d;
      flip_q  <= flip_d;
      vbl_q   <= i_video_vblank;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      blank_q <= blank_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign o_ready        = ready_q;
  assign o_rdata        = rdata_q;
  assign o_overlay_data = data_q;
  assign o_overlay_mask = mask_q;

endmodule

// File: doc/video_sprite_array.md
# video_sprite_array

Parametrised hardware sprite engine for the video overlay path: N independently positioned WIDTH×HEIGHT 8-bit-indexed sprites, fixed index priority, per-sprite enable and horizontal flip, transparent colour key, vblank-latched position registers and an optional sticky collision detector. It sits on the video peripheral bus next to the framebuffer scanout and feeds the overlay mux with data and mask. It replaces the fixed two-sprite block.

## Interface
- SPRITES, 4, sprite count, 1..8
- WIDTH, 32, sprite width in pixels, power of two
- HEIGHT, 32, sprite height in pixels, power of two; WIDTH*HEIGHT ≤ 1024
- TRANSPARENT, 8'h00, pixel value treated as see-through
- i_clock  in  1  single clock for bus and video
- i_reset  in  1  synchronous, active-high reset
- i_request  in  1  bus request, one-cycle pulse
- i_rw  in  1  1 = write, 0 = read
- i_address  in  16  byte address
- i_wdata  in  32  write data
- o_rdata  out  32  read data, valid with o_ready
- o_ready  out  1  one-cycle acknowledge
- i_video_hblank  in  1  horizontal blank
- i_video_vblank  in  1  vertical blank
- i_overlay_x  in  11  current pixel x
- i_overlay_y  in  11  current pixel y
- o_overlay_data  out  8  overlay pixel
- o_overlay_mask  out  1  1 = overlay pixel valid

## Operation
- Address map, i_address[15:12]: 0 = registers; 1..SPRITES = pixel memory of sprite (value−1), pixel index i_address[11:2], row-major; other values acknowledged, ignored, read 0.
- Registers (i_address[11:4] = sprite n < SPRITES, [3:0]): 0 pos_x[10:0]; 4 pos_y[10:0]; 8 control: bit0 enable, bit1 hflip. n ≥ SPRITES: writes ignored, reads 0.
- Global register 12'hFF0: collision status, bit n set when sprite n overlapped another opaque sprite. Read returns and clears; write of 1 to bit n clears bit n.
- Position writes go to shadow registers; shadow copied to active on the first cycle vblank is high after being low. Control writes take effect immediately. Reads return shadow values.
- Pixel memory reads return 0 (write-only); pixel writes store i_wdata[7:0].
- Hit test per sprite: enabled, x−pos_x in [0,WIDTH), y−pos_y in [0,HEIGHT), 11-bit unsigned subtraction (wrap counts as miss). Sample column = dx or WIDTH−1−dx when hflip.
- Pixel opaque if hit and value ≠ TRANSPARENT. Lowest index opaque sprite wins; none → mask 0, data 8'h00. Mask forced 0 during hblank or vblank.

## Timing
- Reset: o_ready 0, o_rdata 0, o_overlay_mask 0, o_overlay_data 0, all positions/controls/collision 0, pipeline cleared. Pixel memory not reset.
- Bus: o_ready and o_rdata exactly one cycle after i_request; back-to-back requests every cycle accepted. Pixel write visible to the overlay from the next cycle.
- Overlay pipeline 2 cycles: stage 1 registers hit/address per sprite and blank state; stage 2 registers memory data, priority select, outputs. Output at cycle t+2 reflects x/y at t.
- Simultaneous collision set and status read: the read returns the old value and the new set bit survives the clear.
- Position write on the same cycle as the vblank copy: the copy uses the old shadow; the new value takes effect at the next vblank.
- Reset mid-frame: outputs 0 from the following cycle; resumes with all sprites disabled.

## Configuration
- VIDEO_SPRITE_COLLISION_EN defined: collision detector and 12'hFF0 register present; bit n set in stage 2 when sprite n and any other sprite are both opaque at an active pixel.
- Undefined: no detector logic; 12'hFF0 reads 0, writes ignored; all other behaviour identical.

## Test plan
- Reset, read 0x0000/0x0008 -> o_rdata 0 one cycle after request, mask 0 on every pixel.
- Write sprite 0 pixel 0 = 8'h5A, pos (100,50), enable, toggle vblank -> at x=100,y=50 mask 1, data 8'h5A two cycles later; x=99 -> mask 0.
- Write pos_x 200 mid-frame, no vblank -> sprite stays at 100; after vblank edge it appears at 200.
- Sprite 0 and sprite 1 opaque on the same pixel -> data from sprite 0; disable sprite 0 -> sprite 1 data; pixel = TRANSPARENT on sprite 0 -> sprite 1 shown.
- hflip=1, pixel 0 = 8'h11, WIDTH 32 -> 8'h11 appears at pos_x+31, not pos_x.
- With VIDEO_SPRITE_COLLISION_EN: overlap sprites 0/2 -> 12'hFF0 reads 32'h5, next read 32'h0; without the macro it reads 0.
